// File: rtl/div_iter_ctrl.sv
// Iterative restoring divider with its sequencer for the execute stage.
// Handles signed and unsigned divide. It accepts one operation at a time and
// stalls the requester while it runs. Quotient and remainder go to LO and HI.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; operands are latched on accept
// BUSY   | one restoring shift/subtract step per cycle, ITER steps in total
// DONE   | results registered; ready pulses for this single cycle
//
// ITER must equal WIDTH: each step retires exactly one quotient bit.
module div_iter_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             stall
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;     // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             q_bit;
  logic [WIDTH-1:0] step_rem, step_quo;

  // Operand magnitudes, and one restoring step on a WIDTH+1-bit difference
  always_comb begin
    dvd_mag  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    shifted  = {prem_q, dvd_q[WIDTH-1]};
    diff     = shifted - {1'b0, dvs_q};
    q_bit    = ~diff[WIDTH];
    step_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    step_quo = {dvd_q[WIDTH-2:0], q_bit};
  end

  // Next-state, datapath updates and result write on entry to DONE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prem_d     = prem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          prem_d     = '0;
          dvd_d      = dvd_mag;
          dvs_d      = dvs_mag;
          neg_quot_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d  = is_signed & dividend[WIDTH-1];
          cnt_d      = '0;
          if (divisor == '0) begin
            // Divide-by-zero skips the iterations; the remainder is the raw dividend
            quot_d  = '1;
            rem_d   = dividend;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          prem_d = step_rem;
          dvd_d  = step_quo;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            quot_d  = neg_quot_q ? -step_quo : step_quo;
            rem_d   = neg_rem_q  ? -step_rem : step_rem;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // A start held in this cycle belongs to the next instruction and is taken in IDLE
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prem_q     <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prem_q     <= prem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
    end
  end

  // Status and result outputs
  always_comb begin
    busy      = (state_q == S_BUSY);
    ready     = (state_q == S_DONE);
    stall     = start & ~ready;
    quotient  = quot_q;
    remainder = rem_q;
  end

endmodule

// File: doc/div_iter_ctrl.md
Name: div_iter_ctrl

Overview:
- Multi-cycle iterative divider and its sequencer for the execute stage.
- Serves the two divide encodings (ALU_SIGNED_DIV, ALU_UNSIGNED_DIV).
- Accepts one division at a time, stalls the pipeline while running, and delivers quotient/remainder for HI/LO write-back.
- Runs a 32-step restoring algorithm on operand magnitudes, with sign fix-up and a flush/cancel path.

Parameters:
- WIDTH, 32, operand and result width.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  division requested by the E-stage instruction; held high until ready is seen.
- is_signed  in  1  1 for ALU_SIGNED_DIV, 0 for ALU_UNSIGNED_DIV; sampled at accept.
- dividend  in  WIDTH  rs operand; sampled at accept.
- divisor  in  WIDTH  rt operand; sampled at accept.
- flush  in  1  cancels any in-flight division (exception/pipeline flush).
- busy  out  1  high while in BUSY state.
- ready  out  1  one-cycle pulse; quotient/remainder valid.
- quotient  out  WIDTH  result to LO.
- remainder  out  WIDTH  result to HI.
- stall  out  1  combinational: start & ~ready.

Behaviour:
- Reset (resetn low, async): state=IDLE; busy=0, ready=0, quotient=0, remainder=0, counter=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 & flush=0 -> accept: latch |dividend|, |divisor| (two's complement magnitude when is_signed, else raw), sign_q=is_signed&(dividend[31]^divisor[31]), sign_r=is_signed&dividend[31], counter=0.
  - Next state: BUSY, or DONE directly if divisor==0.
- BUSY, one step per cycle:
  - Shift the {partial remainder, dividend} pair left by 1.
  - Trial-subtract the divisor magnitude on a WIDTH+1-bit difference.
  - Non-negative difference: keep it, set quotient bit 1. Otherwise restore, bit 0.
  - counter increments; after step ITER-1 -> DONE.
- DONE:
  - ready=1 for exactly this cycle.
  - quotient/remainder registers are written on entry to DONE, as sign-fixed values: negate quotient if sign_q, negate remainder if sign_r.
  - Next state: IDLE unconditionally; start is ignored in DONE.
- Latency: accept at cycle 0 -> ready at cycle ITER+1 (33); busy high cycles 1..32.
- Divide-by-zero: ready at cycle 1; quotient=all-ones, remainder=dividend as presented (raw, no sign fix-up), signed or unsigned.
- Overflow case 0x80000000 / -1 signed: quotient=0x80000000, remainder=0 (magnitude arithmetic wraps naturally, no trap).
- Result hold: quotient/remainder hold their values from DONE until the next DONE. They do not change on accept or flush.
- Flush:
  - Any state -> IDLE on the next edge; no ready pulse; result registers unchanged.
  - In DONE, ready still pulses that cycle and the results are already written; flush only forces IDLE, which happens anyway.
  - flush and start in the same IDLE cycle: flush wins, no accept.
- Handshake: requester holds start and operands stable until ready. The pipeline advances in the ready cycle, so start deasserts or changes to the next instruction. A start seen in IDLE after DONE is a new division.
- stall is high from the first cycle start is asserted, including the accept cycle, through the cycle before ready.

Test Plan:
- Unsigned 100/7 -> quotient=14, remainder=2; ready exactly 33 cycles after accept; busy high 32 cycles; stall high 33 cycles.
- Signed -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1. Unsigned 0xFFFFFFF9/2 -> quotient=0x7FFFFFFC, remainder=1.
- 0x12345678/0, both signedness -> ready 1 cycle after accept; quotient=0xFFFFFFFF, remainder=0x12345678; busy never asserts.
- 0x80000000/0xFFFFFFFF -> signed: quotient=0x80000000, remainder=0. Unsigned: quotient=0, remainder=0x80000000.
- Complete 100/7, then start 50/3 with flush pulsed at BUSY step 10 -> busy low next cycle, no ready, outputs stay 14/2. Restart 50/3 -> quotient=16, remainder=2 after 33 cycles.
- resetn driven low mid-BUSY, asynchronously between clock edges -> busy, ready, quotient and remainder read 0 immediately. After release, a fresh 9/4 yields quotient=2, remainder=1.
